// File: rtl/date_if.sv
// Strobe and date-field bundle between the control side and the calendar stage.
interface date_if;
  logic       inc_auto;
  logic       inc_manual;
  logic       dec_manual;
  logic [1:0] sel;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       carry_out;

  modport master (
    output inc_auto, inc_manual, dec_manual, sel,
    input  day, month, year, carry_out
  );

  modport slave (
    input  inc_auto, inc_manual, dec_manual, sel,
    output day, month, year, carry_out
  );
endinterface

// File: rtl/date_counter.sv
// Calendar stage: day/month/two-digit year with auto day carry and manual field set.
// Define DATE_LEAP_EN to give February 29 days in years divisible by four.
module date_counter #(
  parameter int YEAR_MAX = 99
) (
  input logic   clk,
  input logic   rst_n,
  date_if.slave bus
);

  localparam logic [6:0] YMAX = 7'(YEAR_MAX);

  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_q, year_d;
  logic       carry_q, carry_d;

  logic [3:0] m_norm, m_up, m_dn;
  logic [4:0] d_norm, dim_cur;
  logic [6:0] yr_inc, yr_up, yr_dn;
  logic       leap_cur, leap_up, leap_dn;

  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim_of = 5'd30;
      4'd2:                    dim_of = leap ? 5'd29 : 5'd28;
      default:                 dim_of = 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] lim);
    clamp_day = (d > lim) ? lim : d;
  endfunction

  // Illegal month/day values fold back to 1 so any strobe recovers the state.
  assign m_norm  = (month_q == 4'd0 || month_q > 4'd12) ? 4'd1 : month_q;
  assign d_norm  = (day_q == 5'd0) ? 5'd1 : day_q;
  assign m_up    = (m_norm == 4'd12) ? 4'd1 : m_norm + 4'd1;
  assign m_dn    = (m_norm == 4'd1) ? 4'd12 : m_norm - 4'd1;
  assign yr_inc  = year_q + 7'd1;
  assign yr_up   = (year_q >= YMAX) ? 7'd0 : yr_inc;
  assign yr_dn   = (year_q == 7'd0) ? YMAX : year_q - 7'd1;

`ifdef DATE_LEAP_EN
  assign leap_cur = (year_q[1:0] == 2'b00);
  assign leap_up  = (yr_up[1:0] == 2'b00);
  assign leap_dn  = (yr_dn[1:0] == 2'b00);
`else
  assign leap_cur = 1'b0;
  assign leap_up  = 1'b0;
  assign leap_dn  = 1'b0;
`endif

  assign dim_cur = dim_of(m_norm, leap_cur);

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    carry_d = 1'b0;
    if (bus.inc_auto) begin
      month_d = m_norm;
      if (d_norm < dim_cur) begin
        day_d = d_norm + 5'd1;
      end else begin
        day_d = 5'd1;
        if (m_norm == 4'd12) begin
          month_d = 4'd1;
          year_d  = yr_up;
          carry_d = (year_q >= YMAX);
        end else begin
          month_d = m_norm + 4'd1;
        end
      end
    end else if (bus.inc_manual ^ bus.dec_manual) begin
      case (bus.sel)
        2'd0: begin
          month_d = m_norm;
          if (bus.inc_manual)
            day_d = (d_norm >= dim_cur) ? 5'd1 : d_norm + 5'd1;
          else if (d_norm == 5'd1)
            day_d = dim_cur;
          else
            day_d = clamp_day(d_norm - 5'd1, dim_cur);
        end
        2'd1: begin
          month_d = bus.inc_manual ? m_up : m_dn;
          day_d   = clamp_day(d_norm, dim_of(month_d, leap_cur));
        end
        2'd2: begin
          month_d = m_norm;
          year_d  = bus.inc_manual ? yr_up : yr_dn;
          day_d   = clamp_day(d_norm, dim_of(m_norm, bus.inc_manual ? leap_up : leap_dn));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 7'd0;
      carry_q <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      carry_q <= carry_d;
    end
  end

  assign bus.day       = day_q;
  assign bus.month     = month_q;
  assign bus.year      = year_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter with a reference-model scoreboard.
module tb_date_counter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  date_if bus ();
  date_counter #(.YEAR_MAX(99)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int d; int m; int y; int c; } exp_t;
  exp_t sb[$];
  int md, mm, my, mc;
  int n_assert = 0;
  int n_fail   = 0;

`ifdef DATE_LEAP_EN
  localparam int FEB24 = 29;
`else
  localparam int FEB24 = 28;
`endif

  function automatic int mdim(int m, int y);
    if (m == 2) begin
`ifdef DATE_LEAP_EN
      return (y % 4 == 0) ? 29 : 28;
`else
      return 28;
`endif
    end
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_date(string tag, int d, int m, int y, int c);
    chk({tag, ".day"},   int'(bus.day),       d);
    chk({tag, ".month"}, int'(bus.month),     m);
    chk({tag, ".year"},  int'(bus.year),      y);
    chk({tag, ".carry"}, int'(bus.carry_out), c);
  endtask

  task automatic model_step(int ia, int im, int dm, int s);
    mc = 0;
    if (ia != 0) begin
      if (md < mdim(mm, my)) md++;
      else begin
        md = 1;
        if (mm == 12) begin
          mm = 1;
          if (my == 99) begin my = 0; mc = 1; end
          else my++;
        end else mm++;
      end
    end else if (im != dm && s != 3) begin
      case (s)
        0: if (im != 0) md = (md == mdim(mm, my)) ? 1 : md + 1;
           else         md = (md == 1) ? mdim(mm, my) : md - 1;
        1: begin
          if (im != 0) mm = (mm == 12) ? 1 : mm + 1;
          else         mm = (mm == 1) ? 12 : mm - 1;
          if (md > mdim(mm, my)) md = mdim(mm, my);
        end
        default: begin
          if (im != 0) my = (my == 99) ? 0 : my + 1;
          else         my = (my == 0) ? 99 : my - 1;
          if (md > mdim(mm, my)) md = mdim(mm, my);
        end
      endcase
    end
  endtask

  task automatic step(string tag, int ia, int im, int dm, int s);
    exp_t e;
    @(negedge clk);
    bus.inc_auto   = 1'(ia);
    bus.inc_manual = 1'(im);
    bus.dec_manual = 1'(dm);
    bus.sel        = 2'(s);
    model_step(ia, im, dm, s);
    sb.push_back('{md, mm, my, mc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_date(tag, e.d, e.m, e.y, e.c);
    bus.inc_auto   = 1'b0;
    bus.inc_manual = 1'b0;
    bus.dec_manual = 1'b0;
    bus.sel        = 2'd3;
  endtask

  // Reset asserted between edges must show on the outputs before any clock.
  task automatic async_reset(string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_date(tag, 1, 1, 0, 0);
    md = 1; mm = 1; my = 0; mc = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_date(int d, int m, int y);
    async_reset("set_rst");
    for (int i = 0; i < y; i++)     step("set_y", 0, 1, 0, 2);
    for (int i = 1; i < m; i++)     step("set_m", 0, 1, 0, 1);
    for (int i = 1; i < d; i++)     step("set_d", 0, 1, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.inc_auto = 1'b0; bus.inc_manual = 1'b0; bus.dec_manual = 1'b0; bus.sel = 2'd3;
    md = 1; mm = 1; my = 0; mc = 0;
    repeat (4) @(posedge clk);
    #1;
    chk_date("in_reset", 1, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_date("after_reset", 1, 1, 0, 0);

    for (int i = 0; i < 30; i++) step("auto_jan", 1, 0, 0, 3);
    chk_date("jan31", 31, 1, 0, 0);
    step("auto_feb", 1, 0, 0, 3);
    chk_date("feb1", 1, 2, 0, 0);
    step("auto_feb2", 1, 0, 0, 3);
    async_reset("mid_reset");
    step("post_reset", 1, 0, 0, 3);
    chk_date("resume", 2, 1, 0, 0);

    set_date(28, 2, 24);
    step("leap_auto", 1, 0, 0, 3);
    if (FEB24 == 29) chk_date("feb29_24", 29, 2, 24, 0);
    else             chk_date("mar1_24", 1, 3, 24, 0);
    set_date(28, 2, 23);
    step("nonleap_auto", 1, 0, 0, 3);
    chk_date("mar1_23", 1, 3, 23, 0);

    set_date(31, 12, 99);
    step("century", 1, 0, 0, 3);
    chk_date("century_wrap", 1, 1, 0, 1);
    step("century_idle", 0, 0, 0, 3);
    chk_date("carry_clear", 1, 1, 0, 0);

    set_date(31, 3, 24);
    step("mon_dec", 0, 0, 1, 1);
    chk_date("clamp_feb", FEB24, 2, 24, 0);
    step("yr_inc", 0, 1, 0, 2);
    chk_date("clamp_yr", 28, 2, 25, 0);
    step("yr_dec", 0, 0, 1, 2);
    step("mon_inc_wrap", 0, 1, 0, 1);
    step("day_inc", 0, 1, 0, 0);

    set_date(15, 6, 10);
    step("prio_auto", 1, 1, 0, 1);
    chk_date("prio", 16, 6, 10, 0);
    step("both_manual", 0, 1, 1, 1);
    chk_date("no_change", 16, 6, 10, 0);
    step("sel_none", 0, 1, 0, 3);
    chk_date("sel3", 16, 6, 10, 0);
    set_date(1, 6, 10);
    step("day_dec_wrap", 0, 0, 1, 0);
    chk_date("jun30", 30, 6, 10, 0);
    step("day_inc_wrap", 0, 1, 0, 0);
    chk_date("jun1", 1, 6, 10, 0);
    step("yr_dec_wrap", 0, 0, 0, 3);
    set_date(1, 1, 0);
    step("yr0_dec", 0, 0, 1, 2);
    chk_date("yr99", 1, 1, 99, 0);
    step("mon1_dec", 0, 0, 1, 1);
    chk_date("dec", 1, 12, 99, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
